// File: rtl/uart_rx.sv
// 8N1-style serial receiver (DATA_BITS data, no parity) with a one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as the 2-of-3 vote of the last three ticks up to mid-bit.
module uart_rx #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int SAMPLE_RATE = 16,
    parameter int DATA_BITS   = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 overrun
);
    localparam int DIV   = CLK_HZ / (BAUD_RATE * SAMPLE_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W = $clog2(SAMPLE_RATE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] HALF_LAST = SMP_W'(SAMPLE_RATE / 2 - 1);
    localparam logic [SMP_W-1:0] FULL_LAST = SMP_W'(SAMPLE_RATE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nx;
    logic                 rx_m, rx_s;
    logic [DIV_W-1:0]     div_cnt;
    logic [SMP_W-1:0]     smp_cnt;
    logic [SMP_W-1:0]     mid_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 mid;
    logic                 bit_val;
    logic                 deliver;
    logic                 frame_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Holding the counters at zero in IDLE phase-aligns ticks to the start edge.
    assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    assign mid_cnt = (state == START) ? HALF_LAST : FULL_LAST;
    assign mid     = tick && (smp_cnt == mid_cnt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                smp_cnt <= (smp_cnt == mid_cnt) ? '0 : smp_cnt + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // The two previous tick samples; at mid-bit they are the ticks at mid-2 and mid-1.
    logic [1:0] early;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            early <= 2'b11;
        else if (tick)
            early <= {early[0], rx_s};
    end

    assign bit_val = (early[1] & early[0]) | (early[1] & rx_s) | (early[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        deliver   = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_nx = START;
            START: if (mid) state_nx = bit_val ? IDLE : DATA;
            DATA:  if (mid && (bit_cnt == BIT_LAST)) state_nx = STOP;
            STOP: begin
                if (mid) begin
                    state_nx  = IDLE;
                    deliver   = bit_val;
                    frame_err = !bit_val;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (state != DATA)
                bit_cnt <= '0;
            else if (mid)
                bit_cnt <= bit_cnt + 1'b1;
            // LSB first: each new bit enters at the top, so the first one ends in bit 0.
            if ((state == DATA) && mid)
                shift <= DATA_BITS'({bit_val, shift} >> 1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_err;
            overrun       <= deliver && valid && !ready;
            if (deliver && (!valid || ready)) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx against a cycle-scheduled behavioural model (160 clocks per bit).
// Build with or without UART_RX_MAJORITY_VOTE_EN to match the RTL.
module tb_uart_rx;
    localparam int CPB = 160;
    // Start edge driven after cycle s: 2 sync + 1 IDLE->START + 10 clocks * (8 + 16*10) ticks.
    localparam int LAT = 1683;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       ready   = 1'b0;
    logic [8:0] data;
    logic       valid, busy, framing_error, overrun;

    uart_rx #(.CLK_HZ(1_536_000), .BAUD_RATE(9600), .SAMPLE_RATE(16), .DATA_BITS(9)) dut (
        .clock(clock), .reset_n(reset_n), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .busy(busy), .framing_error(framing_error), .overrun(overrun));

    always #5 clock = ~clock;

    int n_vec = 0, n_err = 0, cyc = 0;
    int ready_pct = 100, ready_mode = 0;
    logic ready_man = 1'b0;

    // Model: scheduled events keyed by cycle number, resolved against the handshake each posedge.
    logic [8:0] m_data = '0;
    logic m_valid = 1'b0, m_busy = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    int         ev_kind [int];
    logic [8:0] ev_word [int];
    bit         b_on [int];
    bit         b_off [int];

    function automatic void sched(input int s, input logic [8:0] w, input bit good);
        b_on[s + 3]     = 1'b1;
        b_off[s + LAT]  = 1'b1;
        ev_kind[s + LAT] = good ? 1 : 2;
        ev_word[s + LAT] = w;
    endfunction

    always @(posedge clock) begin : mdl
        logic vprev, acc;
        cyc   = cyc + 1;
        vprev = m_valid;
        acc   = vprev && ready;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        m_valid = vprev && !acc;
        if (ev_kind.exists(cyc)) begin
            if (ev_kind[cyc] == 1) begin
                if (!vprev || acc) begin
                    m_data  = ev_word[cyc];
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else begin
                m_fe = 1'b1;
            end
            ev_kind.delete(cyc);
            ev_word.delete(cyc);
        end
        if (b_on.exists(cyc)) begin m_busy = 1'b1; b_on.delete(cyc); end
        if (b_off.exists(cyc)) begin m_busy = 1'b0; b_off.delete(cyc); end
    end

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic pin(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d (0x%0h), want %0d (0x%0h)", nm, cyc, act, act, exp, exp);
        end
    endtask

    always @(negedge clock) begin
        check("data", data, m_data);
        check("valid", 9'(valid), 9'(m_valid));
        check("busy", 9'(busy), 9'(m_busy));
        check("framing_error", 9'(framing_error), 9'(m_fe));
        check("overrun", 9'(overrun), 9'(m_ov));
    end

    // Observation counters for the literal pins.
    int n_rise = 0, n_fe = 0, n_ov = 0, rise_cyc = 0;
    logic [8:0] rise_data = '0;
    logic valid_q = 1'b0;
    always @(negedge clock) begin
        if (valid && !valid_q) begin
            n_rise++;
            rise_cyc  = cyc;
            rise_data = data;
        end
        valid_q = valid;
        if (framing_error) n_fe++;
        if (overrun) n_ov++;
    end

    initial forever begin
        @(posedge clock);
        #1;
        ready = (ready_mode != 0) ? ($urandom_range(0, 99) < ready_pct) : ready_man;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        rx      = 1'b1;
        ev_kind.delete(); ev_word.delete(); b_on.delete(); b_off.delete();
        m_data = '0; m_valid = 1'b0; m_busy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        idle(n);
        reset_n = 1'b1;
    endtask

    // One frame, one bit per CPB clocks. stop_low > 0 holds the stop bit low for that many clocks
    // from its start; glitch_at forces one low clock; abort_at resets the DUT at that offset.
    task automatic send(input logic [8:0] w, input int stop_low, input int glitch_at,
                        input int abort_at, input logic [8:0] exp_w);
        int s;
        logic [10:0] bits;
        s    = cyc;
        bits = {1'b1, w, 1'b0};
        sched(s, exp_w, stop_low == 0);
        for (int c = 0; c < 11 * CPB; c++) begin
            if (c == abort_at) begin
                do_reset(5);
                return;
            end
            if (c >= 10 * CPB)
                rx = ((c - 10 * CPB) < stop_low) ? 1'b0 : 1'b1;
            else
                rx = bits[c / CPB];
            if (c == glitch_at) rx = 1'b0;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int s0, r0, f0, o0;
        logic [8:0] w;
        bit bad;

        idle(5);
        reset_n = 1'b1;
        idle(2000);
        pin("reset_data", int'(data), 0);
        pin("reset_valid", int'(valid), 0);
        pin("reset_busy", int'(busy), 0);
        pin("reset_pulses", n_fe + n_ov, 0);

        ready_man = 1'b1;
        idle(2);
        r0 = n_rise;
        s0 = cyc;
        send(9'h1A5, 0, -1, -1, 9'h1A5);
        pin("single_data", int'(rise_data), 'h1A5);
        pin("single_rises", n_rise - r0, 1);
        pin("single_latency", rise_cyc - s0, 1683);
        pin("model_single", int'(m_data), 'h1A5);

        ready_man = 1'b0;
        idle(2);
        o0 = n_ov;
        send(9'h001, 0, -1, -1, 9'h001);
        send(9'h1FF, 0, -1, -1, 9'h1FF);
        pin("b2b_overrun", n_ov - o0, 1);
        pin("b2b_data", int'(data), 'h001);
        pin("b2b_valid", int'(valid), 1);
        ready_man = 1'b1;
        idle(3);
        pin("b2b_release", int'(valid), 0);

        // Stop bit low just past its mid-bit sample, so the line is high again when IDLE resumes.
        f0 = n_fe;
        r0 = n_rise;
        send(9'h055, 81, -1, -1, 9'h055);
        pin("fe_pulse", n_fe - f0, 1);
        pin("fe_no_valid", n_rise - r0, 0);
        pin("fe_idle", int'(busy), 0);
        send(9'h0AA, 0, -1, -1, 9'h0AA);
        pin("fe_next", int'(rise_data), 'h0AA);

        // 40-clock low glitch: rejected at mid start bit, busy for 3 + 8 ticks * 10 clocks.
        f0 = n_fe;
        r0 = n_rise;
        s0 = cyc;
        b_on[s0 + 3]   = 1'b1;
        b_off[s0 + 83] = 1'b1;
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(300);
        pin("glitch_busy", int'(busy), 0);
        pin("glitch_no_valid", n_rise - r0, 0);
        pin("glitch_no_fe", n_fe - f0, 0);

        f0 = n_fe;
        o0 = n_ov;
        send(9'h133, 0, -1, 880, 9'h133);
        pin("rst_mid_busy", int'(busy), 0);
        pin("rst_mid_valid", int'(valid), 0);
        pin("rst_mid_pulses", (n_fe - f0) + (n_ov - o0), 0);
        idle(20);
        send(9'h133, 0, -1, -1, 9'h133);
        pin("rst_mid_next", int'(rise_data), 'h133);

`ifdef UART_RX_MAJORITY_VOTE_EN
        send(9'h1FF, 0, 240, -1, 9'h1FF);
        pin("vote_glitch", int'(rise_data), 'h1FF);
`else
        send(9'h1FF, 0, 240, -1, 9'h1FE);
        pin("vote_glitch", int'(rise_data), 'h1FE);
`endif

        // Break for 1800 clocks: frame of zeros with a low stop bit, then an immediate restart
        // two cycles before the return to IDLE in start-edge terms; the line rises before its
        // first data sample, so the second frame reads all ones.
        f0 = n_fe;
        r0 = n_rise;
        s0 = cyc;
        sched(s0, 9'h000, 1'b0);
        sched(s0 + 1681, 9'h1FF, 1'b1);
        rx = 1'b0;
        idle(1800);
        rx = 1'b1;
        idle(1800);
        pin("break_fe", n_fe - f0, 1);
        pin("break_rises", n_rise - r0, 1);
        pin("break_data", int'(rise_data), 'h1FF);
        pin("break_idle", int'(busy), 0);

        ready_mode = 1;
        for (int i = 0; i < 16; i++) begin
            w         = 9'($urandom);
            bad       = ($urandom_range(0, 4) == 0);
            ready_pct = $urandom_range(0, 100);
            send(w, bad ? 81 : 0, -1, -1, w);
            idle($urandom_range(0, 200));
        end
        ready_mode = 0;
        ready_man  = 1'b1;
        idle(50);
        pin("final_valid", int'(valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
